passcode_controller: RTL and testbench

//   Sequences the button receiver for the timing-attack demo: arms it, waits for a 4-digit

---
 rtl/passcode_pkg.sv | 34 +++
 rtl/passcode_if.sv | 24 ++
 rtl/delay_timer.sv | 24 ++
 rtl/passcode_controller.sv | 161 ++++++++++++++++
 tb/tb_passcode_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/passcode_pkg.sv
// Shared types and constants for the passcode controller.
package passcode_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] INVALID_DIGIT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COLLECT,
    CHECK,
    PASS,
    FAIL,
    LOCKED
  } state_e;

  function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] code,
                                                   input logic [1:0]        idx);
    logic [CODE_W-1:0] shifted;
    shifted = code >> {idx, 1'b0};
    return shifted[DIGIT_W-1:0];
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/passcode_if.sv
// Handshake and status bundle between the passcode controller and its environment.
interface passcode_if;
  logic       start;
  logic       rx_done;
  logic [7:0] rx_code;
  logic [7:0] secret;
  logic       rx_restart;
  logic       busy;
  logic [1:0] digit_idx;
  logic       unlocked;
  logic       denied;
  logic       locked;
  logic [3:0] fail_count;

  modport master (
    output start, rx_done, rx_code, secret,
    input  rx_restart, busy, digit_idx, unlocked, denied, locked, fail_count
  );

  modport slave (
    input  start, rx_done, rx_code, secret,
    output rx_restart, busy, digit_idx, unlocked, denied, locked, fail_count
  );
endinterface

// File: rtl/delay_timer.sv
// Up-counter cleared by load; done flags the terminal count and the count holds there.
module delay_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count_q <= '0;
    end else if (!done) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign done = (count_q == terminal);

endmodule

// File: rtl/passcode_controller.sv
// Arms the button receiver, latches a 4-digit entry and checks it digit by digit,
// then holds the result and enforces lockout after repeated failures.
module passcode_controller
  import passcode_pkg::*;
#(
  parameter int unsigned DIGIT_DELAY_CYCLES = 50_000_000,
  parameter int unsigned RESULT_HOLD_CYCLES = 100_000_000,
  parameter int unsigned MAX_FAILS          = 3,
  parameter int unsigned LOCKOUT_CYCLES     = 500_000_000,
  parameter int unsigned CONSTANT_TIME      = 0
) (
  input  logic       clk,
  input  logic       reset,
  passcode_if.slave  bus
);

  localparam int unsigned MAX_CYC = max3(DIGIT_DELAY_CYCLES, RESULT_HOLD_CYCLES,
                                         LOCKOUT_CYCLES);
  localparam int unsigned TW      = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] DIGIT_TC = TW'(DIGIT_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_TC  = TW'(RESULT_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_TC  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAILS);
  localparam logic [1:0]    LAST_IDX = 2'(NUM_DIGITS - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          mm_q, mm_d, mm_next;
  logic [3:0]    fail_q, fail_d, fail_inc;
  logic [7:0]    rx_q, rx_d, sec_q, sec_d;
  logic          first_q;
  logic          unlocked_q, denied_q, locked_q;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_tc;
  logic [1:0]    rx_digit, sec_digit;
  logic          digit_ok;

  assign rx_digit  = get_digit(rx_q, idx_q);
  assign sec_digit = get_digit(sec_q, idx_q);
  assign digit_ok  = (rx_digit == sec_digit) && (rx_digit != INVALID_DIGIT);
  assign fail_inc  = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 4'd1;

  // Timer runs only in timed states and restarts from zero on every terminal count.
  always_comb begin
    tmr_tc   = DIGIT_TC;
    tmr_load = 1'b1;
    case (state_q)
      CHECK:     begin tmr_tc = DIGIT_TC; tmr_load = tmr_done; end
      PASS,
      FAIL:      begin tmr_tc = HOLD_TC;  tmr_load = tmr_done; end
      LOCKED:    begin tmr_tc = LOCK_TC;  tmr_load = tmr_done; end
      default:   ;
    endcase
  end

  delay_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .terminal (tmr_tc),
    .done     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mm_d    = mm_q;
    mm_next = mm_q | ~digit_ok;
    fail_d  = fail_q;
    rx_d    = rx_q;
    sec_d   = sec_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = ARM;
      end
      ARM: begin
        state_d = COLLECT;
      end
      COLLECT: begin
        // A rx_done still high from the previous entry is ignored in the first cycle.
        if (bus.rx_done && !first_q) begin
          rx_d    = bus.rx_code;
          sec_d   = bus.secret;
          idx_d   = '0;
          mm_d    = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (tmr_done) begin
          if (!digit_ok && (CONSTANT_TIME == 0)) begin
            state_d = FAIL;
            fail_d  = fail_inc;
          end else if (idx_q == LAST_IDX) begin
            if (mm_next) begin
              state_d = FAIL;
              fail_d  = fail_inc;
            end else begin
              state_d = PASS;
              fail_d  = '0;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            mm_d  = mm_next;
          end
        end
      end
      PASS: begin
        if (tmr_done) state_d = IDLE;
      end
      FAIL: begin
        if (tmr_done) state_d = (fail_q == FAIL_MAX) ? LOCKED : IDLE;
      end
      LOCKED: begin
        if (tmr_done) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mm_q       <= 1'b0;
      fail_q     <= '0;
      rx_q       <= '0;
      sec_q      <= '0;
      first_q    <= 1'b0;
      unlocked_q <= 1'b0;
      denied_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mm_q       <= mm_d;
      fail_q     <= fail_d;
      rx_q       <= rx_d;
      sec_q      <= sec_d;
      first_q    <= (state_q == ARM);
      unlocked_q <= (state_q == PASS);
      denied_q   <= (state_q == FAIL);
      locked_q   <= (state_q == LOCKED);
    end
  end

  assign bus.rx_restart = (state_q == ARM);
  assign bus.busy       = (state_q != IDLE);
  assign bus.digit_idx  = (state_q == CHECK) ? idx_q : 2'd0;
  assign bus.unlocked   = unlocked_q;
  assign bus.denied     = denied_q;
  assign bus.locked     = locked_q;
  assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_passcode_controller.sv
// Directed bench: a leaky instance (b0) and a constant-time instance (b1).
module tb_passcode_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  int   lat;

  always #5 clk = ~clk;

  passcode_if b0();
  passcode_if b1();

  passcode_controller #(
    .DIGIT_DELAY_CYCLES (4),
    .RESULT_HOLD_CYCLES (3),
    .MAX_FAILS          (3),
    .LOCKOUT_CYCLES     (10),
    .CONSTANT_TIME      (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  passcode_controller #(
    .DIGIT_DELAY_CYCLES (4),
    .RESULT_HOLD_CYCLES (3),
    .MAX_FAILS          (3),
    .LOCKOUT_CYCLES     (10),
    .CONSTANT_TIME      (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return b0.unlocked;
      1:       return b0.denied;
      2:       return b1.denied;
      default: return 1'b0;
    endcase
  endfunction

  // Counts cycles after the latch edge until the selected output rises (bounded).
  task automatic wait_hi(input int sel, input int budget, output int n);
    n = 0;
    while (!pick(sel) && n < budget) begin
      tick();
      n++;
    end
  endtask

  // IDLE -> ARM -> COLLECT; returns in the first COLLECT cycle.
  task automatic start_attempt(input string tag);
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    chk({tag, "_restart_hi"}, 32'(b0.rx_restart), 1);
    tick();
    chk({tag, "_restart_lo"}, 32'(b0.rx_restart), 0);
  endtask

  task automatic latch(input logic [7:0] code, input logic [7:0] sec);
    b0.rx_code = code;
    b0.secret  = sec;
    b0.rx_done = 1'b1;
    tick();
    b0.rx_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b0.start = 1'b0; b0.rx_done = 1'b0; b0.rx_code = '0; b0.secret = '0;
    b1.start = 1'b0; b1.rx_done = 1'b0; b1.rx_code = '0; b1.secret = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy",     32'(b0.busy),       0);
    chk("rst_restart",  32'(b0.rx_restart), 0);
    chk("rst_idx",      32'(b0.digit_idx),  0);
    chk("rst_unlocked", 32'(b0.unlocked),   0);
    chk("rst_denied",   32'(b0.denied),     0);
    chk("rst_locked",   32'(b0.locked),     0);
    chk("rst_fails",    32'(b0.fail_count), 0);
    chk("rst_busy1",    32'(b1.busy),       0);

    // Constant-time instance: mismatch at digit 0 still takes the full 4-digit time
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    tick();
    tick();
    b1.rx_code = 8'b10_01_00_10;
    b1.secret  = 8'b10_01_00_01;
    b1.rx_done = 1'b1;
    tick();
    b1.rx_done = 1'b0;
    repeat (8) tick();
    chk("ct_idx_walk", 32'(b1.digit_idx), 2);
    lat = 8;
    while (!b1.denied && lat < 40) begin
      tick();
      lat++;
    end
    chk("ct_deny_lat",  lat, 17);
    chk("ct_unlocked",  32'(b1.unlocked),   0);
    chk("ct_fails",     32'(b1.fail_count), 1);

    // Correct entry unlocks after 4*D+1 cycles for H cycles
    start_attempt("t1");
    chk("t1_busy", 32'(b0.busy), 1);
    tick();
    latch(8'b10_01_00_01, 8'b10_01_00_01);
    wait_hi(0, 40, lat);
    chk("t1_unlock_lat", lat, 17);
    chk("t1_fails", 32'(b0.fail_count), 0);
    chk("t1_denied", 32'(b0.denied), 0);
    tick();
    chk("t1_hold2", 32'(b0.unlocked), 1);
    tick();
    chk("t1_hold3", 32'(b0.unlocked), 1);
    tick();
    chk("t1_hold_end", 32'(b0.unlocked), 0);
    chk("t1_idle", 32'(b0.busy), 0);

    // Leaky: mismatch at digit 0
    start_attempt("t2a");
    tick();
    latch(8'b10_01_00_10, 8'b10_01_00_01);
    wait_hi(1, 40, lat);
    chk("t2a_deny_lat", lat, 5);
    chk("t2a_fails", 32'(b0.fail_count), 1);
    repeat (3) tick();
    chk("t2a_hold_end", 32'(b0.denied), 0);
    chk("t2a_idle", 32'(b0.busy), 0);

    // Leaky: mismatch at digit 2, digit_idx walks 0,1,2
    start_attempt("t2b");
    tick();
    latch(8'b10_10_00_01, 8'b10_01_00_01);
    chk("t2b_idx0", 32'(b0.digit_idx), 0);
    repeat (4) tick();
    chk("t2b_idx1", 32'(b0.digit_idx), 1);
    repeat (4) tick();
    chk("t2b_idx2", 32'(b0.digit_idx), 2);
    repeat (4) tick();
    chk("t2b_idx_out", 32'(b0.digit_idx), 0);
    chk("t2b_deny_early", 32'(b0.denied), 0);
    tick();
    chk("t2b_deny_lat13", 32'(b0.denied), 1);
    chk("t2b_fails", 32'(b0.fail_count), 2);
    repeat (3) tick();
    chk("t2b_idle", 32'(b0.busy), 0);

    // Third failure -> lockout for 10 cycles; start ignored meanwhile
    start_attempt("t4");
    tick();
    latch(8'b00_00_00_00, 8'b10_01_00_01);
    wait_hi(1, 40, lat);
    chk("t4_deny_lat", lat, 5);
    chk("t4_fails", 32'(b0.fail_count), 3);
    repeat (3) tick();
    chk("t4_denied_off", 32'(b0.denied), 0);
    chk("t4_locked_on", 32'(b0.locked), 1);
    chk("t4_excl_unl", 32'(b0.unlocked), 0);
    b0.start = 1'b1;
    tick();
    chk("t4_start_ign", 32'(b0.rx_restart), 0);
    tick();
    b0.start = 1'b0;
    repeat (7) tick();
    chk("t4_locked_last", 32'(b0.locked), 1);
    chk("t4_fails_clr", 32'(b0.fail_count), 0);
    tick();
    chk("t4_locked_off", 32'(b0.locked), 0);
    chk("t4_idle", 32'(b0.busy), 0);
    chk("t4_no_arm", 32'(b0.rx_restart), 0);

    // Reset mid-CHECK aborts with no partial result
    start_attempt("t5");
    tick();
    latch(8'b10_01_00_01, 8'b10_01_00_01);
    repeat (5) tick();
    chk("t5_pre_idx", 32'(b0.digit_idx), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy",     32'(b0.busy),       0);
    chk("t5_idx",      32'(b0.digit_idx),  0);
    chk("t5_unlocked", 32'(b0.unlocked),   0);
    chk("t5_restart",  32'(b0.rx_restart), 0);
    repeat (15) tick();
    chk("t5_no_result", 32'(b0.unlocked), 0);
    chk("t5_still_idle", 32'(b0.busy), 0);
    start_attempt("t5b");
    b0.start = 1'b1;
    tick();
    chk("t5_busy_start1", 32'(b0.rx_restart), 0);
    tick();
    chk("t5_busy_start2", 32'(b0.rx_restart), 0);
    b0.start = 1'b0;
    latch(8'b10_01_00_01, 8'b10_01_00_01);
    wait_hi(0, 40, lat);
    chk("t5_unlock_lat", lat, 17);
    repeat (3) tick();

    // All-invalid code is denied; stale rx_done in first COLLECT cycle not latched
    start_attempt("t6");
    b0.rx_code = 8'hFF;
    b0.secret  = 8'hFF;
    b0.rx_done = 1'b1;
    tick();
    b0.rx_done = 1'b0;
    repeat (3) tick();
    chk("t6_no_check", 32'(b0.denied), 0);
    latch(8'hFF, 8'hFF);
    wait_hi(1, 40, lat);
    chk("t6_deny_lat", lat, 5);
    chk("t6_unlocked", 32'(b0.unlocked), 0);
    chk("t6_fails", 32'(b0.fail_count), 1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
